// File: rtl/user_clock_ctrl.sv
// User clock sequencer: generates the slow student clock from CLOCK_50 with free-run, pause,
// N-step bursts and an LED-pattern breakpoint, all driven by a valid/ready command port.
module user_clock_ctrl #(
   parameter int DIVIDE_BY = 25000000,
   parameter bit RESET_RUN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_arg,
   input  logic [7:0]  led,
   output logic        clk_div,
   output logic        tick,
   output logic        running,
   output logic        bp_hit,
   output logic [31:0] cycle_count
);

   localparam int CW = (DIVIDE_BY > 2) ? $clog2(DIVIDE_BY) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(DIVIDE_BY - 1);
   localparam logic [CW-1:0] CNT_MID = CW'(DIVIDE_BY / 2 - 1);

   localparam logic [1:0] OP_PAUSE = 2'd0;
   localparam logic [1:0] OP_RUN   = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_SETBP = 2'd3;

   typedef enum logic [1:0] {
      ST_PAUSED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_BREAK  = 2'd3
   } state_t;

   generate
      if (DIVIDE_BY < 2) begin : g_badDivide
         $error("user_clock_ctrl: DIVIDE_BY must be at least 2");
      end
   endgenerate

   state_t        r_state;
   state_t        w_nextState;
   logic [CW-1:0] r_cnt;
   logic          r_clkDiv;
   logic          r_tick;
   logic [31:0]   r_cycleCount;
   logic [15:0]   r_stepLeft;
   logic          r_bpEn;
   logic [7:0]    r_bpPat;
   logic          r_skipBp;

   logic w_active;
   logic w_atTop;
   logic w_atMid;
   logic w_accept;
   logic w_acceptPause;
   logic w_acceptRun;
   logic w_acceptStep;
   logic w_acceptSetBp;
   logic w_stateCmd;
   logic w_bpFire;
   logic w_edge;
   logic w_stepDone;

   assign w_active      = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_atTop       = (r_cnt == CNT_TOP);
   assign w_atMid       = (r_cnt == CNT_MID);
   assign w_accept      = cmd_valid && cmd_ready;
   assign w_acceptPause = w_accept && (cmd_op == OP_PAUSE);
   assign w_acceptRun   = w_accept && (cmd_op == OP_RUN);
   assign w_acceptStep  = w_accept && (cmd_op == OP_STEP);
   assign w_acceptSetBp = w_accept && (cmd_op == OP_SETBP);
   assign w_stateCmd    = w_acceptPause || w_acceptRun || w_acceptStep;

   // A state-changing command at the top of the period overrides the breakpoint; the
   // first edge after leaving PAUSED/BREAK ignores it so the user can step off a match.
   assign w_bpFire   = w_atTop && w_active && r_bpEn && (led == r_bpPat) && !r_skipBp && !w_stateCmd;
   assign w_edge     = w_atTop && w_active && !w_acceptPause && !w_bpFire;
   assign w_stepDone = w_edge && (r_state == ST_STEP) && (r_stepLeft == 16'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RESET_RUN ? ST_RUN : ST_PAUSED;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (w_acceptPause) begin
         w_nextState = ST_PAUSED;
      end else if (w_acceptRun) begin
         w_nextState = ST_RUN;
      end else if (w_acceptStep) begin
         w_nextState = ST_STEP;
      end else if (w_bpFire) begin
         w_nextState = ST_BREAK;
      end else if (w_stepDone) begin
         w_nextState = ST_PAUSED;
      end
   end

   always_comb begin
      cmd_ready = (r_state != ST_STEP) || (cmd_op == OP_PAUSE);
      running   = w_active;
      bp_hit    = (r_state == ST_BREAK);
   end

   // Prescaler keeps running while clk_div is high so that a pause never cuts a high phase short.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= '0;
         r_clkDiv     <= 1'b0;
         r_tick       <= 1'b0;
         r_cycleCount <= 32'd0;
         r_stepLeft   <= 16'd0;
         r_bpEn       <= 1'b0;
         r_bpPat      <= 8'd0;
         r_skipBp     <= 1'b0;
      end else begin
         if (w_bpFire) begin
            r_cnt <= '0;
         end else if (w_active || r_clkDiv) begin
            r_cnt <= w_atTop ? '0 : r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end

         if (w_edge) begin
            r_clkDiv <= 1'b1;
         end else if (w_atMid) begin
            r_clkDiv <= 1'b0;
         end

         r_tick <= w_edge;

         if (w_edge) begin
            r_cycleCount <= r_cycleCount + 32'd1;
         end

         if (w_acceptPause) begin
            r_stepLeft <= 16'd0;
         end else if (w_acceptStep) begin
            r_stepLeft <= (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
         end else if (w_edge && (r_state == ST_STEP)) begin
            r_stepLeft <= r_stepLeft - 16'd1;
         end

         if (w_acceptSetBp) begin
            r_bpEn  <= cmd_arg[8];
            r_bpPat <= cmd_arg[7:0];
         end

         if ((w_acceptRun || w_acceptStep) && !w_active) begin
            r_skipBp <= 1'b1;
         end else if (w_edge) begin
            r_skipBp <= 1'b0;
         end
      end
   end

   assign clk_div     = r_clkDiv;
   assign tick        = r_tick;
   assign cycle_count = r_cycleCount;

endmodule
